// File: rtl/dut_bus_pkg.sv
// rtl/dut_bus_pkg.sv - shared types and constants for the dut bus master
package dut_bus_pkg;

  localparam int ADDR_W = 3;

  // dut address map
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_A      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_B      = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_Y      = 3'd3;

  typedef struct packed {
    logic              is_read;
    logic [ADDR_W-1:0] address;
    logic              data;
  } cmd_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              data;
  } rsp_t;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_DROP  = 1'b1
  } stall_state_e;

endpackage

// File: rtl/dut_bus_master_if.sv
// rtl/dut_bus_master_if.sv - command/response streams and dut method ports
interface dut_bus_master_if;
  import dut_bus_pkg::*;

  // command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_is_read;
  logic [ADDR_W-1:0] cmd_address;
  logic              cmd_data;
  // response stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_address;
  logic              rsp_data;
  // dut write method
  logic [ADDR_W-1:0] write_address;
  logic              write_data;
  logic              write_en;
  logic              write_rdy;
  // dut read method
  logic [ADDR_W-1:0] read_address;
  logic              read_en;
  logic              read_data;
  logic              read_rdy;
  // error reporting
  logic              timeout_err;
  logic [7:0]        drop_count;

  // the sequencer side
  modport master (
    input  cmd_valid, cmd_is_read, cmd_address, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_address, rsp_data,
    input  rsp_ready,
    output write_address, write_data, write_en,
    input  write_rdy,
    output read_address, read_en,
    input  read_data, read_rdy,
    output timeout_err, drop_count
  );

  // the environment side: command producer, response consumer and dut
  modport slave (
    output cmd_valid, cmd_is_read, cmd_address, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_address, rsp_data,
    output rsp_ready,
    input  write_address, write_data, write_en,
    output write_rdy,
    input  read_address, read_en,
    output read_data, read_rdy,
    input  timeout_err, drop_count
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // a push while full is accepted only because the same-cycle pop frees the slot
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // pointer advance; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // storage write; contents need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dut_bus_master.sv
// rtl/dut_bus_master.sv - queues commands, issues them to dut ports, drops stalled heads
module dut_bus_master
  import dut_bus_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  dut_bus_master_if.master  bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  cmd_t             cmd_in;
  cmd_t             head;
  logic             cmd_full;
  logic             cmd_empty;
  logic             cmd_push;
  logic             cmd_pop;
  logic             head_valid;

  rsp_t             rsp_in;
  rsp_t             rsp_head;
  logic             rsp_full;
  logic             rsp_empty;
  logic             rsp_pop;

  stall_state_e     state_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             timeout_err_q;
  logic [7:0]       drop_count_q;

  logic             in_issue;
  logic             wr_fire;
  logic             rd_fire;
  logic             stall;

  // command side: ready follows registered occupancy only, and is low in reset
  assign bus.cmd_ready = ~RST & ~cmd_full;
  assign cmd_push      = bus.cmd_valid & bus.cmd_ready;
  assign cmd_in        = '{is_read: bus.cmd_is_read,
                           address: bus.cmd_address,
                           data:    bus.cmd_data};

  sync_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .pop_data  (head),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

  assign head_valid = ~cmd_empty;
  assign in_issue   = (state_q == ST_ISSUE) & ~RST;

  // en pulses are combinational so a command retires in the cycle its rdy is seen
  assign wr_fire = head_valid & in_issue & ~head.is_read & bus.write_rdy;
  assign rd_fire = head_valid & in_issue &  head.is_read & bus.read_rdy & ~rsp_full;
  assign stall   = head_valid & (state_q == ST_ISSUE) & ~wr_fire & ~rd_fire;

  assign bus.write_en      = wr_fire;
  assign bus.read_en       = rd_fire;
  assign bus.write_address = head_valid ? head.address : '0;
  assign bus.write_data    = head_valid ? head.data    : 1'b0;
  assign bus.read_address  = head_valid ? head.address : '0;

  // the DROP cycle retires the head without any en
  assign cmd_pop = wr_fire | rd_fire | (head_valid & (state_q == ST_DROP));

  // response side
  assign rsp_in  = '{address: head.address, data: bus.read_data};
  assign rsp_pop = ~rsp_empty & bus.rsp_ready;

  sync_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (rd_fire),
    .push_data (rsp_in),
    .pop       (rsp_pop),
    .pop_data  (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty)
  );

  assign bus.rsp_valid   = ~rsp_empty;
  assign bus.rsp_address = rsp_head.address;
  assign bus.rsp_data    = rsp_head.data;

  assign bus.timeout_err = timeout_err_q;
  assign bus.drop_count  = drop_count_q;

  // stall FSM: count consecutive non-issuing head cycles, drop the head on expiry
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_ISSUE;
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      drop_count_q  <= 8'd0;
    end else if (state_q == ST_ISSUE) begin
      if (stall) begin
        if (stall_cnt_q == CNT_LAST) begin
          state_q     <= ST_DROP;
          stall_cnt_q <= '0;
        end else begin
          stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
      end else begin
        stall_cnt_q <= '0;
      end
    end else begin
      state_q       <= ST_ISSUE;
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b1;
      if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_dut_bus_master.sv
// tb/tb_dut_bus_master.sv - scoreboard bench for dut_bus_master
module tb_dut_bus_master;
  import dut_bus_pkg::*;

  typedef struct {
    logic [2:0] a;
    logic       d;
  } ev_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dut_bus_master_if bus ();

  dut_bus_master #(
    .CMD_DEPTH (4),
    .RSP_DEPTH (4),
    .TIMEOUT   (16)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  ev_t        exp_wr[$];
  logic [2:0] exp_rd[$];
  ev_t        exp_rsp[$];
  int checks    = 0;
  int failures  = 0;
  int rd_en_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every en pulse and every accepted response is compared to the scoreboard
  always @(negedge CLK) begin
    ev_t        e;
    logic [2:0] ra;
    if (RST === 1'b0) begin
      if (bus.write_en || bus.read_en) begin
        check("one_en_only", {31'd0, bus.write_en & bus.read_en}, 32'd0);
      end
      if (bus.write_en) begin
        check("write_en_needs_rdy", {31'd0, bus.write_rdy}, 32'd1);
        if (exp_wr.size() == 0) begin
          check("unexpected_write_en", 32'd1, 32'd0);
        end else begin
          e = exp_wr.pop_front();
          check("write_address", {29'd0, bus.write_address}, {29'd0, e.a});
          check("write_data", {31'd0, bus.write_data}, {31'd0, e.d});
        end
      end
      if (bus.read_en) begin
        rd_en_cnt++;
        check("read_en_needs_rdy", {31'd0, bus.read_rdy}, 32'd1);
        if (exp_rd.size() == 0) begin
          check("unexpected_read_en", 32'd1, 32'd0);
        end else begin
          ra = exp_rd.pop_front();
          check("read_address", {29'd0, bus.read_address}, {29'd0, ra});
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_address", {29'd0, bus.rsp_address}, {29'd0, e.a});
          check("rsp_data", {31'd0, bus.rsp_data}, {31'd0, e.d});
        end
      end
    end
  end

  task automatic push_cmd(input logic rd, input logic [2:0] a, input logic d);
    int n;
    n = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_is_read = rd;
    bus.cmd_address = a;
    bus.cmd_data    = d;
    @(negedge CLK);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("cmd_accept_in_time", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge CLK);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_rsp.size()) != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("drain_in_time", {31'd0, (n < 100)}, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.cmd_valid   = 1'b0;
    bus.cmd_is_read = 1'b0;
    bus.cmd_address = 3'd0;
    bus.cmd_data    = 1'b0;
    bus.rsp_ready   = 1'b1;
    bus.write_rdy   = 1'b0;
    bus.read_rdy    = 1'b0;
    bus.read_data   = 1'b0;
    RST             = 1'b1;

    // reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_write_en", {31'd0, bus.write_en}, 32'd0);
    check("rst_read_en", {31'd0, bus.read_en}, 32'd0);
    check("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    check("rst_drop_count", {24'd0, bus.drop_count}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge CLK);
    #1;

    // single write: one pulse, in the cycle after acceptance
    bus.write_rdy = 1'b1;
    exp_wr.push_back('{3'd4, 1'b1});
    push_cmd(1'b0, 3'd4, 1'b1);
    @(negedge CLK);
    check("single_write_cycle1", {31'd0, bus.write_en}, 32'd1);
    @(negedge CLK);
    check("single_write_one_pulse", {31'd0, bus.write_en}, 32'd0);
    check("empty_write_address", {29'd0, bus.write_address}, 32'd0);
    wait_drain();

    // read path: read_en in cycle 1, rsp_valid in cycle 2
    bus.read_rdy  = 1'b1;
    bus.read_data = 1'b1;
    exp_rd.push_back(ADDR_Y);
    exp_rsp.push_back('{ADDR_Y, 1'b1});
    push_cmd(1'b1, ADDR_Y, 1'b0);
    @(negedge CLK);
    check("read_en_cycle1", {31'd0, bus.read_en}, 32'd1);
    check("rsp_valid_not_cycle1", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge CLK);
    check("rsp_valid_cycle2", {31'd0, bus.rsp_valid}, 32'd1);
    wait_drain();

    // back-to-back writes with rdy high
    for (int i = 0; i < 4; i++) exp_wr.push_back('{3'(i), 1'(i)});
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 3'(i), 1'(i));
    wait_drain();

    // fill with rdy low, then four consecutive issues
    bus.write_rdy = 1'b0;
    for (int i = 0; i < 4; i++) exp_wr.push_back('{3'(7 - i), 1'(~i)});
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 3'(7 - i), 1'(~i));
    @(negedge CLK);
    check("full_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge CLK);
    #1;
    bus.write_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("b2b_write_en", {31'd0, bus.write_en}, 32'd1);
    end
    @(negedge CLK);
    check("b2b_done_write_en", {31'd0, bus.write_en}, 32'd0);
    check("b2b_done_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    wait_drain();

    // response backpressure: only RSP_DEPTH reads may issue
    bus.rsp_ready = 1'b0;
    bus.read_data = 1'b0;
    base = rd_en_cnt;
    for (int i = 1; i <= 6; i++) begin
      exp_rd.push_back(3'(i));
      exp_rsp.push_back('{3'(i), 1'b0});
    end
    for (int i = 1; i <= 6; i++) push_cmd(1'b1, 3'(i), 1'b0);
    repeat (3) @(negedge CLK);
    check("bp_read_en_count", rd_en_cnt - base, 32'd4);
    check("bp_read_blocked", {31'd0, bus.read_en}, 32'd0);
    check("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    @(posedge CLK);
    #1;
    bus.rsp_ready = 1'b1;
    wait_drain();
    check("bp_total_reads", rd_en_cnt - base, 32'd6);

    // timeout: 16 stalled cycles, then a DROP cycle that ignores a rising rdy
    bus.write_rdy = 1'b0;
    push_cmd(1'b0, 3'd5, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      check("stall_no_write_en", {31'd0, bus.write_en}, 32'd0);
    end
    @(posedge CLK);
    #1;
    bus.write_rdy = 1'b1;
    @(negedge CLK);
    check("drop_cycle_no_en", {31'd0, bus.write_en}, 32'd0);
    check("drop_cycle_err_not_yet", {31'd0, bus.timeout_err}, 32'd0);
    @(negedge CLK);
    check("timeout_err_set", {31'd0, bus.timeout_err}, 32'd1);
    check("drop_count_one", {24'd0, bus.drop_count}, 32'd1);
    check("dropped_head_gone", {29'd0, bus.write_address}, 32'd0);
    @(posedge CLK);
    #1;
    exp_wr.push_back('{3'd6, 1'b1});
    push_cmd(1'b0, 3'd6, 1'b1);
    wait_drain();
    check("timeout_err_sticky", {31'd0, bus.timeout_err}, 32'd1);

    // reset mid-stream with 2 responses and 3 commands pending
    bus.rsp_ready = 1'b0;
    bus.read_rdy  = 1'b1;
    bus.read_data = 1'b1;
    base = rd_en_cnt;
    exp_rd.push_back(ADDR_A);
    exp_rsp.push_back('{ADDR_A, 1'b1});
    exp_rd.push_back(ADDR_B);
    exp_rsp.push_back('{ADDR_B, 1'b1});
    push_cmd(1'b1, ADDR_A, 1'b0);
    push_cmd(1'b1, ADDR_B, 1'b0);
    @(negedge CLK);
    @(posedge CLK);
    #1;
    bus.read_rdy  = 1'b0;
    bus.write_rdy = 1'b0;
    check("pre_rst_reads", rd_en_cnt - base, 32'd2);
    push_cmd(1'b0, 3'd1, 1'b1);
    push_cmd(1'b0, 3'd2, 1'b0);
    push_cmd(1'b1, 3'd3, 1'b1);
    RST           = 1'b1;
    bus.write_rdy = 1'b1;
    bus.read_rdy  = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    check("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("midrst_write_en", {31'd0, bus.write_en}, 32'd0);
    check("midrst_read_en", {31'd0, bus.read_en}, 32'd0);
    exp_rsp.delete();
    @(negedge CLK);
    check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("postrst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    check("postrst_drop_count", {24'd0, bus.drop_count}, 32'd0);
    check("postrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("postrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("postrst_write_address", {29'd0, bus.write_address}, 32'd0);
    repeat (3) @(negedge CLK);

    check("scoreboard_empty", exp_wr.size() + exp_rd.size() + exp_rsp.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
